// File: rtl/sdrd_pkg.sv
// Shared types and default sizing for the SDRD serial deserializer.
// SDRD_PARITY_EN adds the PAR state used for the trailing odd-parity bit.
package sdrd_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int GAP_MAX_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
`ifdef SDRD_PARITY_EN
      ,PAR  = 2'd2
`endif
   } sdrd_state_e;

endpackage

// File: rtl/sdrd_if.sv
// Serial-in / bus-out signal bundle of the SDRD deserializer.
// The master side drives the serial bits and bus controls; the slave side is the deserializer.
interface sdrd_if
   import sdrd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic             sdrd;
   logic             sdrd_vld;
   logic             rd_stb;
   logic             clr_err;
   logic [WIDTH-1:0] dout;
   logic             rdy;
   logic             busy;
   logic             ovr;
   logic             ferr;

   modport master (
      output sdrd, sdrd_vld, rd_stb, clr_err,
      input  dout, rdy, busy, ovr, ferr
   );

   modport slave (
      input  sdrd, sdrd_vld, rd_stb, clr_err,
      output dout, rdy, busy, ovr, ferr
   );

endinterface

// File: rtl/sdrd_gap_cnt.sv
// Mid-word idle counter: counts idle cycles, saturates at GAP_MAX, and flags
// the idle cycle that reaches GAP_MAX so the word can be aborted on that edge.
module sdrd_gap_cnt
   import sdrd_pkg::*;
#(
   parameter int GAP_MAX = GAP_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(GAP_MAX + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CW'(GAP_MAX))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = inc && (cnt >= CW'(GAP_MAX - 1));

endmodule

// File: rtl/sdrd_deser.sv
// SDRD deserializer: assembles MSB-first serial words into a read-acknowledged
// holding register with sticky overrun/framing flags. SDRD_PARITY_EN adds an odd-parity bit.
module sdrd_deser
   import sdrd_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int GAP_MAX = GAP_MAX_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   sdrd_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SDRD_PARITY_EN
   localparam int SR_W = WIDTH;
`else
   // The final bit goes straight to dout, so only WIDTH-1 bits need holding.
   localparam int SR_W = WIDTH - 1;
`endif

   sdrd_state_e      state;
   logic [SR_W-1:0]  shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] dout_q;
   logic             rdy_q, busy_q, ovr_q, ferr_q;

   logic             gap_clr, gap_inc, gap_exp;
   logic [WIDTH-1:0] shift_nxt, word_val;
   logic             last_bit, word_done, par_err, set_ovr, set_ferr;

   assign gap_clr = (state == IDLE) || bus.sdrd_vld;
   assign gap_inc = (state != IDLE) && !bus.sdrd_vld;

   sdrd_gap_cnt #(.GAP_MAX(GAP_MAX)) u_gap (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (gap_clr),
      .inc     (gap_inc),
      .expired (gap_exp)
   );

   always_comb begin
      shift_nxt = {shreg[WIDTH-2:0], bus.sdrd};
      last_bit  = (state == SHIFT) && bus.sdrd_vld && (bit_cnt == CNT_W'(WIDTH - 1));
`ifdef SDRD_PARITY_EN
      word_done = (state == PAR) && bus.sdrd_vld && (^{shreg, bus.sdrd});
      par_err   = (state == PAR) && bus.sdrd_vld && !(^{shreg, bus.sdrd});
      word_val  = shreg;
`else
      word_done = last_bit;
      par_err   = 1'b0;
      word_val  = shift_nxt;
`endif
      set_ovr  = word_done && rdy_q && !bus.rd_stb;
      set_ferr = gap_exp || par_err;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         dout_q  <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         // A completing word keeps rdy high even when a read lands on the same edge.
         if (word_done) begin
            dout_q <= word_val;
            rdy_q  <= 1'b1;
         end else if (bus.rd_stb) begin
            rdy_q  <= 1'b0;
         end

         if (set_ovr)          ovr_q <= 1'b1;
         else if (bus.clr_err) ovr_q <= 1'b0;

         if (set_ferr)         ferr_q <= 1'b1;
         else if (bus.clr_err) ferr_q <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.sdrd_vld) begin
                  shreg   <= SR_W'(bus.sdrd);
                  bit_cnt <= CNT_W'(1);
                  state   <= SHIFT;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (bus.sdrd_vld) begin
                  shreg   <= shift_nxt[SR_W-1:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (last_bit) begin
`ifdef SDRD_PARITY_EN
                     state  <= PAR;
`else
                     state  <= IDLE;
                     busy_q <= 1'b0;
`endif
                  end
               end else if (gap_exp) begin
                  shreg   <= '0;
                  bit_cnt <= '0;
                  state   <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
`ifdef SDRD_PARITY_EN
            PAR: begin
               if (bus.sdrd_vld || gap_exp) begin
                  shreg   <= '0;
                  bit_cnt <= '0;
                  state   <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
`endif
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout = dout_q;
   assign bus.rdy  = rdy_q;
   assign bus.busy = busy_q;
   assign bus.ovr  = ovr_q;
   assign bus.ferr = ferr_q;

endmodule
